// File: rtl/sigmoid_pkg.sv
// ---------------------------------------------------------------------------
// sigmoid_pkg
// Shared constants and helpers for the PLAN logistic-function block.
//   - Fixed formats: Q4.4 signed input and Q1.14 signed output.
//   - Segment breakpoints, segment offsets and slope shift amounts.
//   - plan_seg(): classifies a magnitude into its PLAN segment.
//   - widen(): zero-extends a magnitude to the output width.
// ---------------------------------------------------------------------------
package sigmoid_pkg;

    // Number formats
    localparam int IN_W     = 32'd8;
    localparam int IN_FRAC  = 32'd4;
    localparam int OUT_W    = 32'd16;
    localparam int OUT_FRAC = 32'd14;

    // Segment lower breakpoints on |x| in Q4.4 units (1.0, 2.375, 5.0)
    localparam logic [IN_W-1:0] BP1 = 8'd16;
    localparam logic [IN_W-1:0] BP2 = 8'd38;
    localparam logic [IN_W-1:0] BP3 = 8'd80;

    // Segment offsets in Q1.14 (0.5, 0.625, 0.84375, 1.0)
    localparam logic [OUT_W-1:0] OFS0 = 16'd8192;
    localparam logic [OUT_W-1:0] OFS1 = 16'd10240;
    localparam logic [OUT_W-1:0] OFS2 = 16'd13824;
    localparam logic [OUT_W-1:0] ONE  = 16'd16384;

    // Slopes 1/4, 1/8, 1/32 expressed as left shifts of the Q4.4 magnitude
    // into Q1.14 (Q4.4 -> Q1.14 is a shift of 10; minus 2, 3 and 5).
    localparam int unsigned SH0 = 32'd8;
    localparam int unsigned SH1 = 32'd7;
    localparam int unsigned SH2 = 32'd5;

    // Which linear piece a magnitude falls on
    typedef enum logic [1:0] {
        SEG_STEEP   = 2'd0,
        SEG_MID     = 2'd1,
        SEG_SHALLOW = 2'd2,
        SEG_SAT     = 2'd3
    } plan_seg_e;

    // Each segment owns its lower breakpoint, so comparisons are strict '<'.
    function automatic plan_seg_e plan_seg(input logic [IN_W-1:0] a);
        plan_seg_e seg;
        if (a < BP1) begin
            seg = SEG_STEEP;
        end else if (a < BP2) begin
            seg = SEG_MID;
        end else if (a < BP3) begin
            seg = SEG_SHALLOW;
        end else begin
            seg = SEG_SAT;
        end
        return seg;
    endfunction

    // Zero-extend an input-width magnitude to the output width.
    function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] a);
        return {{(OUT_W-IN_W){1'b0}}, a};
    endfunction

endpackage

// File: rtl/sigmoid_plan_core.sv
// ---------------------------------------------------------------------------
// sigmoid_plan_core
// Combinational positive-half PLAN sigmoid: p(a) for magnitude a = |x|.
// Ports:
//   a  in   8  unsigned Q4.4 magnitude, 0..128
//   p  out 16  unsigned Q1.14 value, 8192..16384
// All three ramps are computed in parallel and one is selected; each ramp
// only has to be exact inside its own segment, and every in-segment sum
// stays below 2^15, so no saturation is needed apart from the a >= 80 clamp.
// ---------------------------------------------------------------------------
module sigmoid_plan_core
    import sigmoid_pkg::*;
(
    input  logic [IN_W-1:0]  a,
    output logic [OUT_W-1:0] p
);

    logic [OUT_W-1:0] a_w_s;
    logic [OUT_W-1:0] ramp0_s;
    logic [OUT_W-1:0] ramp1_s;
    logic [OUT_W-1:0] ramp2_s;
    plan_seg_e        seg_s;

    // Build the three candidate ramps as offset + shifted magnitude.
    always_comb begin
        a_w_s   = widen(a);
        ramp0_s = OFS0 + (a_w_s << SH0);
        ramp1_s = OFS1 + (a_w_s << SH1);
        ramp2_s = OFS2 + (a_w_s << SH2);
    end

    // Pick the ramp belonging to the segment of a; saturate at 1.0.
    always_comb begin
        seg_s = plan_seg(a);
        case (seg_s)
            SEG_STEEP:   p = ramp0_s;
            SEG_MID:     p = ramp1_s;
            SEG_SHALLOW: p = ramp2_s;
            SEG_SAT:     p = ONE;
            default:     p = ONE;
        endcase
    end

endmodule

// File: rtl/sigmoid.sv
// ---------------------------------------------------------------------------
// sigmoid
// Registered fixed-point logistic function y = 1/(1+e^-x) using the PLAN
// piecewise-linear approximation, mirrored for negative inputs.
// Ports:
//   clk  in   1  rising-edge clock
//   rst  in   1  synchronous active-high reset, clears out to 0
//   x    in   8  signed Q4.4 operand, -8.0 .. +7.9375
//   out  out 16  signed Q1.14 result, 0 .. 16384 (bit 15 is always 0)
// Build option:
//   SIGMOID_IN_REG_EN  when defined, x is registered (cleared by rst) before
//                      the datapath and latency grows from 1 to 2 cycles.
// ---------------------------------------------------------------------------
module sigmoid
    import sigmoid_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] out
);

    logic [IN_W-1:0]  x_dp_s;   // operand seen by the datapath
    logic             neg_s;
    logic [IN_W-1:0]  a_s;
    logic [OUT_W-1:0] p_s;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

`ifdef SIGMOID_IN_REG_EN
    logic [IN_W-1:0] x_d;
    logic [IN_W-1:0] x_q;

    // Next value of the input retiming register.
    always_comb begin
        x_d = x;
    end

    // Input retiming register, cleared by reset like the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= 8'd0;
        end else begin
            x_q <= x_d;
        end
    end

    assign x_dp_s = x_q;
`else
    assign x_dp_s = x;
`endif

    // Sign-magnitude split. For x = -128 the 8-bit negate wraps to 0x80,
    // which read as unsigned is exactly 128, so no extra bit is needed.
    always_comb begin
        neg_s = x_dp_s[IN_W-1];
        if (neg_s) begin
            a_s = 8'd0 - x_dp_s;
        end else begin
            a_s = x_dp_s;
        end
    end

    sigmoid_plan_core u_core (
        .a (a_s),
        .p (p_s)
    );

    // Mirror about 0.5 for negative inputs: sigma(-x) = 1 - sigma(x).
    // p never exceeds ONE, so the subtraction cannot go negative.
    always_comb begin
        if (neg_s) begin
            out_d = ONE - p_s;
        end else begin
            out_d = p_s;
        end
    end

    // Output register; reset takes priority over the computed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 16'd0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_sigmoid.sv
// ---------------------------------------------------------------------------
// tb_sigmoid
// Directed self-checking bench for the PLAN sigmoid block.
// ---------------------------------------------------------------------------
module tb_sigmoid;

`ifdef SIGMOID_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  x;
    logic [15:0] out;

    int checks;
    int failures;

    sigmoid dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .out (out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: the PLAN formula evaluated with integer arithmetic.
    function automatic logic [15:0] model(input logic [7:0] xv);
        int xs;
        int a;
        int p;
        xs = int'($signed(xv));
        a  = (xs < 0) ? -xs : xs;
        if (a < 16)      p = 8192 + 256 * a;
        else if (a < 38) p = 10240 + 128 * a;
        else if (a < 80) p = 13824 + 32 * a;
        else             p = 16384;
        if (xs < 0) p = 16384 - p;
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [15:0] expv);
        checks++;
        assert (out === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, out, expv);
        end
    endtask

    // Drive x just after an edge, wait out the pipeline latency, sample #1 later.
    task automatic apply(input logic [7:0] xv);
        x = xv;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic apply_check(input string tag, input logic [7:0] xv, input logic [15:0] expv);
        apply(xv);
        check(tag, expv);
    endtask

    initial begin
        logic [15:0] prev;
        logic [15:0] pos_v;
        logic [15:0] neg_v;
        logic [7:0]  xv;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        x        = 8'h40;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 16'h0000);

        // Release: value for 0x40 appears after the latency
        rst = 1'b0;
        apply_check("after_reset", 8'h40, 16'h3E00);

        // Sweep 0xC0..0x40 step 4 against the formula, monotonic
        prev = 16'h0000;
        for (int v = -64; v <= 64; v += 4) begin
            xv = v[7:0];
            apply(xv);
            check("sweep", model(xv));
            checks++;
            assert (out >= prev) else begin
                failures++;
                $error("FAIL monotonic x=0x%02h observed=0x%04h expected>=0x%04h", xv, out, prev);
            end
            prev = out;
        end

        // Hand-computed spot values
        apply_check("spot_c0", 8'hC0, 16'h0200);
        apply_check("spot_d8", 8'hD8, 16'h0500);
        apply_check("spot_f0", 8'hF0, 16'h1000);
        apply_check("spot_00", 8'h00, 16'h2000);
        apply_check("spot_10", 8'h10, 16'h3000);
        apply_check("spot_24", 8'h24, 16'h3A00);
        apply_check("spot_28", 8'h28, 16'h3B00);
        apply_check("spot_40", 8'h40, 16'h3E00);

        // Breakpoints
        apply_check("bp_0f", 8'h0F, 16'd12032);
        apply_check("bp_10", 8'h10, 16'd12288);
        apply_check("bp_25", 8'h25, 16'd14976);
        apply_check("bp_26", 8'h26, 16'd15040);
        apply_check("bp_4f", 8'h4F, 16'd16352);
        apply_check("bp_50", 8'h50, 16'd16384);
        apply_check("bp_neg_0f", 8'hF1, 16'd4352);
        apply_check("bp_neg_26", 8'hDA, 16'd1344);

        // Extremes
        apply_check("ext_7f", 8'h7F, 16'h4000);
        apply_check("ext_80", 8'h80, 16'h0000);
        apply_check("ext_b0", 8'hB0, 16'h0000);

        // Symmetry: out(x) + out(-x) == 1.0 for all positive x
        for (int i = 1; i <= 127; i++) begin
            xv = i[7:0];
            apply(xv);
            pos_v = out;
            xv = 8'd0 - xv;
            apply(xv);
            neg_v = out;
            checks++;
            assert ((pos_v + neg_v) === 16'd16384) else begin
                failures++;
                $error("FAIL symmetry x=%0d observed=%0d expected=16384", i, pos_v + neg_v);
            end
        end

        // Reset in the middle of a stream
        apply_check("pre_midrst", 8'h18, 16'd13312);
        x   = 8'hE0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out", 16'h0000);
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        check("midrst_resume", 16'd2048);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
